// File: rtl/ram_bist_ctrl.sv
// March-style RAM self-test sequencer: writes seed^address to all 64 words, reads them back
// through a one-stage compare pipeline and reports the first mismatching address and data.
module ram_bist_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pattern,
    output logic       we,
    output logic [7:0] data,
    output logic [5:0] write_addr,
    output logic [5:0] read_addr,
    input  logic [7:0] q,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] fail_addr,
    output logic [7:0] fail_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [5:0] LAST_ADDR = 6'd63;

    // Value every word should hold for a given seed.
    function automatic logic [7:0] expected_byte(input logic [7:0] seed, input logic [5:0] addr);
        return seed ^ {2'b00, addr};
    endfunction

    state_t     state_q, state_d;
    logic [7:0] seed_q, seed_d;
    logic       we_q, we_d;
    logic [7:0] data_q, data_d;
    logic [5:0] write_addr_q, write_addr_d;
    logic [5:0] read_addr_q, read_addr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [5:0] fail_addr_q, fail_addr_d;
    logic [7:0] fail_data_q, fail_data_d;
    logic       cmp_valid_q, cmp_valid_d;
    logic [5:0] cmp_addr_q, cmp_addr_d;
    logic       mismatch_s;
    logic       accept_s;

    // Sequencer next state: address counters step inside their phase and wrap only on exit.
    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        write_addr_d = write_addr_q;
        read_addr_d  = read_addr_q;
        accept_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_d      = ST_WRITE;
                    seed_d       = pattern;
                    write_addr_d = 6'd0;
                    read_addr_d  = 6'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (write_addr_q == LAST_ADDR) begin
                    state_d      = ST_READ;
                    write_addr_d = 6'd0;
                end else begin
                    write_addr_d = write_addr_q + 6'd1;
                end
            end
            ST_READ: begin
                if (read_addr_q == LAST_ADDR) begin
                    state_d     = ST_DRAIN;
                    read_addr_d = 6'd0;
                end else begin
                    read_addr_d = read_addr_q + 6'd1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Compare pipeline: q returns one cycle after its address, so the address is delayed to match.
    always_comb begin
        cmp_valid_d = (state_q == ST_READ);
        cmp_addr_d  = read_addr_q;
        mismatch_s  = cmp_valid_q && (q != expected_byte(seed_q, cmp_addr_q));
    end

    // Result capture: a new start re-arms, and only the first mismatch of a run is kept.
    always_comb begin
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (accept_s) begin
            pass_d      = 1'b1;
            fail_addr_d = 6'd0;
            fail_data_d = 8'd0;
        end else if (mismatch_s && pass_q) begin
            pass_d      = 1'b0;
            fail_addr_d = cmp_addr_q;
            fail_data_d = q;
        end else begin
            pass_d = pass_q;
        end
    end

    // Output decode from the next state so every port comes straight from a flop.
    always_comb begin
        we_d   = (state_d == ST_WRITE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if (we_d) begin
            data_d = expected_byte(seed_d, write_addr_d);
        end else begin
            data_d = 8'd0;
        end
    end

    // State register with asynchronous reset that abandons any run in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            seed_q       <= 8'd0;
            we_q         <= 1'b0;
            data_q       <= 8'd0;
            write_addr_q <= 6'd0;
            read_addr_q  <= 6'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_addr_q  <= 6'd0;
            fail_data_q  <= 8'd0;
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= 6'd0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            we_q         <= we_d;
            data_q       <= data_d;
            write_addr_q <= write_addr_d;
            read_addr_q  <= read_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_addr_q  <= fail_addr_d;
            fail_data_q  <= fail_data_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_addr_q   <= cmp_addr_d;
        end
    end

    assign we         = we_q;
    assign data       = data_q;
    assign write_addr = write_addr_q;
    assign read_addr  = read_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: a 64x8 RAM with injectable stuck-at bits, a scoreboard of
// expected run outcomes computed from the fault map, and a monitor checking each done pulse.
module tb_ram_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic       we;
    logic [7:0] data;
    logic [5:0] write_addr;
    logic [5:0] read_addr;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] fail_addr;
    logic [7:0] fail_data;

    ram_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .we(we), .data(data), .write_addr(write_addr), .read_addr(read_addr),
        .q(q), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    typedef struct {
        logic [7:0] pat;
        logic       pass;
        logic [5:0] faddr;
        logic [7:0] fdata;
        int         done_cyc;
    } exp_t;

    logic [7:0] mem [64];
    logic [7:0] s0  [64];
    logic [7:0] s1  [64];
    exp_t       sb[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    exp_t       mon_e;
    int         mon_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM with registered read; stuck-at faults corrupt what is read back.
    always @(posedge clk) begin
        if (we) mem[write_addr] <= data;
        q <= (mem[read_addr] & ~s0[read_addr]) | s1[read_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outcome: every word should read pattern^addr; first address that doesn't wins.
    function automatic exp_t model(input logic [7:0] pat);
        exp_t       e;
        logic [7:0] want;
        logic [7:0] got;
        e.pat = pat; e.pass = 1'b1; e.faddr = 6'd0; e.fdata = 8'd0; e.done_cyc = 0;
        for (int a = 0; a < 64; a++) begin
            want = pat ^ 8'(a);
            got  = (want & ~s0[a]) | s1[a];
            if (got != want && e.pass) begin
                e.pass  = 1'b0;
                e.faddr = 6'(a);
                e.fdata = got;
            end
        end
        return e;
    endfunction

    // Monitor: each done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.done_cyc);
                chk("pass", {31'd0, pass}, {31'd0, mon_e.pass});
                chk("fail_addr", {26'd0, fail_addr}, {26'd0, mon_e.faddr});
                chk("fail_data", {24'd0, fail_data}, {24'd0, mon_e.fdata});
                mon_bad = 0;
                for (int a = 0; a < 64; a++) begin
                    if (mem[a] !== (mon_e.pat ^ 8'(a))) mon_bad++;
                end
                chk("ram_image_bad_words", mon_bad, 0);
            end
        end
    end

    task automatic clear_faults();
        for (int a = 0; a < 64; a++) begin
            s0[a] = 8'd0;
            s1[a] = 8'd0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_sb(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run(input logic [7:0] pat, input bit poke);
        exp_t e;
        wait_idle();
        pattern = pat;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = model(pat);
        e.done_cyc = cyc + 129;
        sb.push_back(e);
        if (poke) begin
            repeat ($urandom_range(5, 120)) @(negedge clk);
            pattern = ~pat;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
            pattern = pat;
        end
        wait_sb(400);
        @(negedge clk);
        chk("pass_hold", {31'd0, pass}, {31'd0, e.pass});
        chk("fail_addr_hold", {26'd0, fail_addr}, {26'd0, e.faddr});
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        int   n1;
        int   n;
        rst = 1'b0; start = 1'b0; pattern = 8'd0;
        clear_faults();
        #1 rst = 1'b1;
        #2;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_busy_done_pass", {29'd0, busy, done, pass}, 32'd0);
        chk("rst_addrs", {20'd0, write_addr, read_addr}, 32'd0);
        chk("rst_data_fail", {10'd0, data, fail_addr, fail_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Clean RAM, seed 0xA5.
        run(8'hA5, 1'b0);
        chk("a5_word_03", {24'd0, mem[3]}, 32'h0000_00A6);
        chk("a5_word_3f", {24'd0, mem[63]}, 32'h0000_009A);
        chk("a5_pass", {31'd0, pass}, 32'd1);

        // Single stuck-at-0 on bit 0 of word 5.
        s0[5] = 8'h01;
        run(8'h00, 1'b0);
        chk("sa0_fail_addr", {26'd0, fail_addr}, 32'h05);
        chk("sa0_fail_data", {24'd0, fail_data}, 32'h04);

        // Two faults: the earlier address must be retained.
        s1[16] = 8'h01;
        run(8'h00, 1'b0);
        chk("two_fault_addr", {26'd0, fail_addr}, 32'h05);

        // Clean run right after a failing one.
        clear_faults();
        run(8'hFF, 1'b0);
        chk("b2b_pass", {31'd0, pass}, 32'd1);
        chk("b2b_fail_addr", {26'd0, fail_addr}, 32'd0);

        // Start held high: one done per run, second run starts one IDLE cycle after DONE.
        wait_idle();
        pattern = 8'h5A;
        start   = 1'b1;
        @(posedge clk);
        #1;
        n1 = cyc;
        e1 = model(8'h5A);
        e1.done_cyc = n1 + 129;
        e2 = e1;
        e2.done_cyc = n1 + 260;
        sb.push_back(e1);
        sb.push_back(e2);
        n = 0;
        while (cyc < n1 + 133 && n < 300) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        wait_sb(400);

        // Reset in the middle of WRITE, then restart on the first edge after release.
        wait_idle();
        pattern = 8'h3C;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        @(negedge clk);
        while (write_addr != 6'h20 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_addr_20", {26'd0, write_addr}, 32'h20);
        #2 rst = 1'b1;
        #1;
        chk("midrst_we", {31'd0, we}, 32'd0);
        chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("midrst_outputs", {1'd0, pass, write_addr, data, fail_addr, fail_data}, 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        pattern = 8'hC3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e1 = model(8'hC3);
        e1.done_cyc = cyc + 129;
        sb.push_back(e1);
        wait_sb(400);

        // Randomized runs with random stuck-at faults and stray starts while busy.
        for (int r = 0; r < 6; r++) begin
            int nf;
            int fa;
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++) begin
                fa = $urandom_range(0, 63);
                if ($urandom_range(0, 1) == 1) s0[fa] = s0[fa] | (8'd1 << $urandom_range(0, 7));
                else                           s1[fa] = s1[fa] | (8'd1 << $urandom_range(0, 7));
            end
            run(8'($urandom), 1'b1);
        end

        clear_faults();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, test request; sampled only in IDLE.
REQ-004 SHALL have port pattern, input, 8, seed byte; latched when start is accepted.
REQ-005 SHALL have port we, output, 1, RAM write enable.
REQ-006 SHALL have port data, output, 8, RAM write data.
REQ-007 SHALL have port write_addr, output, 6, RAM write address.
REQ-008 SHALL have port read_addr, output, 6, RAM read address.
REQ-009 SHALL have port q, input, 8, RAM read data; registered by the RAM, valid one cycle after read_addr is presented.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-012 SHALL have port pass, output, 1, result; valid from done until the next accepted start.
REQ-013 SHALL have port fail_addr, output, 6, address of the first mismatch.
REQ-014 SHALL have port fail_data, output, 8, q value read at the first mismatch.

Function
REQ-015 SHALL implement the states IDLE, WRITE, READ, DRAIN and DONE.
REQ-016 SHALL leave IDLE only when start=1 at a rising edge, going to WRITE, and SHALL latch pattern into seed at that edge.
REQ-017 SHALL, in WRITE, hold we=1 and step write_addr 0..63 one per cycle, with data = seed XOR {2'b00, write_addr}, then go to READ after address 63.
REQ-018 SHALL, in READ, hold we=0 and step read_addr 0..63 one per cycle, then go to DRAIN for exactly one cycle.
REQ-019 SHALL compare q against the expected value of the read_addr issued in the previous cycle, through a one-stage address/expected pipeline; compares are active from the second READ cycle through DRAIN, 64 compares in total.
REQ-020 SHALL, on the first mismatch only, capture fail_addr and fail_data and clear the pass flag; later mismatches SHALL NOT overwrite the captured values.
REQ-021 SHALL continue the full sweep after a mismatch; there is no early abort.
REQ-022 SHALL move from DRAIN to DONE, assert done=1 for exactly one cycle, and then return to IDLE.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL accept a start sampled in the same cycle that DONE returns to IDLE at the next IDLE edge, not in the DONE cycle itself.
REQ-025 SHALL assert done in the 130th cycle after the start-sampling edge: 64 WRITE + 64 READ + 1 DRAIN + 1 DONE.
REQ-026 SHALL, when a new start is accepted, set pass to 1 and clear fail_addr and fail_data to 0.
REQ-027 SHALL hold we=0 at all times outside WRITE.
REQ-028 SHALL wrap the 6-bit address counters from 63 to 0 only on state exit, and SHALL NOT emit an address beyond 63.

Reset
REQ-029 SHALL, while rst=1, immediately force state=IDLE, we=0, data=0, write_addr=0, read_addr=0, busy=0, done=0, pass=0, fail_addr=0 and fail_data=0, independent of clk.
REQ-030 SHALL, on reset mid-operation, abandon the test with no done pulse; RAM contents are left as partially written.
REQ-031 SHALL return to normal operation at the first rising edge after rst deasserts, with start sampled at that edge.

Verification
REQ-032 Reset: rst pulse mid-WRITE at write_addr=0x20 -> we=0 within the same cycle, busy=0, no done pulse, and a subsequent start runs a full 130-cycle test.
REQ-033 Clean RAM, pattern=0xA5 -> address 0x03 written with 0xA6 and address 0x3F written with 0x9A; done exactly 130 cycles after start, pass=1, fail_addr=0, fail_data=0.
REQ-034 Fault model with bit 0 of address 0x05 stuck-at-0, pattern=0x00 (expected 0x05) -> pass=0, fail_addr=0x05, fail_data=0x04.
REQ-035 Two faults at addresses 0x05 and 0x10 -> fail_addr=0x05 retained after done.
REQ-036 start held high throughout a run -> exactly one done pulse per run, and the next run begins at the first IDLE edge after DONE.
REQ-037 Back-to-back runs, a failing run followed by pattern=0xFF on a clean RAM -> the second run reports pass=1 and fail_addr=0.
